// File: rtl/adc_window_pkg.sv
// adc_window_pkg -- shared definitions for the ADC window sequencer.
//   * default counter widths for adc_window_sequencer
//   * sequencer state enum; its encodings double as the CSR readout
//     codes so software sees the same values as the FSM register.
package adc_window_pkg;

  localparam int unsigned COUNT_WIDTH_DEF = 16;
  localparam int unsigned EVENT_WIDTH_DEF = 32;

  localparam logic [2:0] STATE_CODE_IDLE    = 3'd0;
  localparam logic [2:0] STATE_CODE_ARMED   = 3'd1;
  localparam logic [2:0] STATE_CODE_ACQUIRE = 3'd2;
  localparam logic [2:0] STATE_CODE_LATCH   = 3'd3;
  localparam logic [2:0] STATE_CODE_HOLDOFF = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = STATE_CODE_IDLE,
    ST_ARMED   = STATE_CODE_ARMED,
    ST_ACQUIRE = STATE_CODE_ACQUIRE,
    ST_LATCH   = STATE_CODE_LATCH,
    ST_HOLDOFF = STATE_CODE_HOLDOFF
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- loadable, saturating up-counter with a limit compare.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (count -> 0)
//   load         load load_value (has priority over inc)
//   load_value   value loaded on load
//   inc          increment by one; holds at all-ones
//   limit        compare value
//   count        registered count
//   hit          the value being written this cycle (load or inc) equals limit
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             hit
);

  logic [WIDTH-1:0] count_nx;

  always_comb begin
    count_nx = count;
    if (load) begin
      count_nx = load_value;
    end else if (inc && (count != '1)) begin
      count_nx = count + WIDTH'(1);
    end
  end

  assign hit = (load | inc) & (count_nx == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nx;
    end
  end

endmodule

// File: rtl/adc_window_sequencer.sv
// adc_window_sequencer -- single-pass self-trigger sequencer for the ADC
// statistics path (adcClk domain). Arms on request, waits for the threshold
// flag, gates the RMS accumulators over the use-this-sample window, latches,
// applies a holdoff and optionally re-arms.
// Optional feature macro: ADC_WINDOW_TIMEOUT_EN (adds adcTimeout/adcForced:
// a forced window of adcMaxWindow samples when no threshold arrives in time).
// Ports:
//   adcClk, adcReset      clock, asynchronous active-high reset
//   adcArm / adcAbort     single-cycle arm / abort requests (abort wins)
//   adcAutoRearm          re-arm after holdoff
//   adcHoldoff            valid samples to wait after latch
//   adcMaxWindow          window cap in valid samples, 0 = no cap
//   adcValid, adcExceedsThreshold, adcUseThisSample   sample strobe + flags
//   adcAccClear/Enable/Latch   accumulator controls (registered)
//   adcArmed, adcBusy     status
//   adcWindowLength       valid samples in the last completed window
//   adcEventCount         completed windows since reset
module adc_window_sequencer
  import adc_window_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int unsigned EVENT_WIDTH = EVENT_WIDTH_DEF
) (
  input  logic                   adcClk,
  input  logic                   adcReset,
  input  logic                   adcArm,
  input  logic                   adcAbort,
  input  logic                   adcAutoRearm,
  input  logic [COUNT_WIDTH-1:0] adcHoldoff,
  input  logic [COUNT_WIDTH-1:0] adcMaxWindow,
  input  logic                   adcValid,
  input  logic                   adcExceedsThreshold,
  input  logic                   adcUseThisSample,
`ifdef ADC_WINDOW_TIMEOUT_EN
  input  logic [COUNT_WIDTH-1:0] adcTimeout,
  output logic                   adcForced,
`endif
  output logic                   adcAccClear,
  output logic                   adcAccEnable,
  output logic                   adcAccLatch,
  output logic                   adcArmed,
  output logic                   adcBusy,
  output logic [COUNT_WIDTH-1:0] adcWindowLength,
  output logic [EVENT_WIDTH-1:0] adcEventCount
);

  state_t state, state_nx;

  logic acc_clear_nx, acc_enable_nx, acc_latch_nx;
  logic trigger, force_start, forced_mode, in_forced;
  logic start_window, window_full;
  logic len_inc, len_hit;
  logic cap_active;
  logic [COUNT_WIDTH-1:0] cap_value, len_count;
  logic hold_load, hold_inc, hold_hit, hold_expired;
  logic [COUNT_WIDTH-1:0] hold_count_unused;

  assign trigger      = adcValid & adcExceedsThreshold;
  assign start_window = (state == ST_ARMED) & ~adcAbort & (trigger | force_start);

  // A forced window ignores adcUseThisSample and is always capped
  // (cap of 1 when adcMaxWindow is 0).
  assign in_forced  = force_start | (forced_mode & (state == ST_ACQUIRE));
  assign cap_active = in_forced | (adcMaxWindow != '0);
  assign cap_value  = (adcMaxWindow == '0) ? COUNT_WIDTH'(1) : adcMaxWindow;
  assign len_inc    = (state == ST_ACQUIRE) & ~adcAbort & adcValid
                    & (adcUseThisSample | forced_mode);
  assign window_full = cap_active & len_hit;

  // The starting sample loads 1 so it counts as the first window sample.
  sat_counter #(.WIDTH(COUNT_WIDTH)) u_len_counter (
    .clk        (adcClk),
    .rst        (adcReset),
    .load       (start_window),
    .load_value (COUNT_WIDTH'(1)),
    .inc        (len_inc),
    .limit      (cap_value),
    .count      (len_count),
    .hit        (len_hit)
  );

  assign hold_load    = (state == ST_LATCH);
  assign hold_inc     = (state == ST_HOLDOFF) & adcValid;
  assign hold_expired = (state == ST_HOLDOFF) & ((adcHoldoff == '0) | hold_hit);

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_hold_counter (
    .clk        (adcClk),
    .rst        (adcReset),
    .load       (hold_load),
    .load_value ('0),
    .inc        (hold_inc),
    .limit      (adcHoldoff),
    .count      (hold_count_unused),
    .hit        (hold_hit)
  );

`ifdef ADC_WINDOW_TIMEOUT_EN
  logic timeout_hit;
  logic [COUNT_WIDTH-1:0] timeout_count_unused;

  // Counts valid samples only while ARMED; held at 0 everywhere else.
  sat_counter #(.WIDTH(COUNT_WIDTH)) u_timeout_counter (
    .clk        (adcClk),
    .rst        (adcReset),
    .load       (state != ST_ARMED),
    .load_value ('0),
    .inc        ((state == ST_ARMED) & adcValid),
    .limit      (adcTimeout),
    .count      (timeout_count_unused),
    .hit        (timeout_hit)
  );

  assign force_start = (state == ST_ARMED) & adcValid & ~adcExceedsThreshold
                     & (adcTimeout != '0) & timeout_hit;

  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      forced_mode <= 1'b0;
      adcForced   <= 1'b0;
    end else begin
      if (start_window) begin
        forced_mode <= force_start;
      end
      if (acc_latch_nx) begin
        adcForced <= forced_mode;
      end else if ((state_nx == ST_ARMED) && (state != ST_ARMED)) begin
        adcForced <= 1'b0;
      end
    end
  end
`else
  assign force_start = 1'b0;
  assign forced_mode = 1'b0;
`endif

  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    acc_clear_nx  = 1'b0;
    acc_enable_nx = 1'b0;
    acc_latch_nx  = 1'b0;
    if (adcAbort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (adcArm) begin
            state_nx     = ST_ARMED;
            acc_clear_nx = 1'b1;
          end
        end
        ST_ARMED: begin
          if (start_window) begin
            acc_enable_nx = 1'b1;
            state_nx      = window_full ? ST_LATCH : ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (adcValid) begin
            if (len_inc) begin
              acc_enable_nx = 1'b1;
              if (window_full) begin
                state_nx = ST_LATCH;
              end
            end else begin
              state_nx = ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          acc_latch_nx = 1'b1;
          state_nx     = ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          if (hold_expired) begin
            if (adcAutoRearm) begin
              state_nx     = ST_ARMED;
              acc_clear_nx = 1'b1;
            end else begin
              state_nx = ST_IDLE;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so status flags line
  // up with the state register.
  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      adcAccClear     <= 1'b0;
      adcAccEnable    <= 1'b0;
      adcAccLatch     <= 1'b0;
      adcArmed        <= 1'b0;
      adcBusy         <= 1'b0;
      adcWindowLength <= '0;
      adcEventCount   <= '0;
    end else begin
      adcAccClear  <= acc_clear_nx;
      adcAccEnable <= acc_enable_nx;
      adcAccLatch  <= acc_latch_nx;
      adcArmed     <= (state_nx == ST_ARMED);
      adcBusy      <= (state_nx != ST_IDLE);
      if (acc_latch_nx) begin
        adcWindowLength <= len_count;
        adcEventCount   <= adcEventCount + EVENT_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/adc_window_sequencer.md
Name: adc_window_sequencer

Overview:
- Single-pass self-trigger sequencer for the ADC statistics path, in the adcClk domain.
- Arms on request and waits for the threshold flag from the ADC processing block.
- Gates the per-channel RMS accumulators over the use-this-sample window, then latches results, applies holdoff, and optionally re-arms.
- Configuration arrives already synchronised into adcClk (forwardData on the system side).

Parameters:
- COUNT_WIDTH, 16, width of window-length, holdoff and timeout counters.
- EVENT_WIDTH, 32, width of the trigger event counter.

Ports:
- adcClk  input  1  ADC sample clock.
- adcReset  input  1  asynchronous, active-high reset.
- adcArm  input  1  single-cycle arm request.
- adcAbort  input  1  single-cycle abort; returns to IDLE.
- adcAutoRearm  input  1  level; re-arm after holdoff.
- adcHoldoff  input  COUNT_WIDTH  samples to wait after latch.
- adcMaxWindow  input  COUNT_WIDTH  window length cap in valid samples; 0 = no cap.
- adcValid  input  1  sample strobe, aligned with the two flags below.
- adcExceedsThreshold  input  1  threshold flag.
- adcUseThisSample  input  1  window flag.
- adcAccClear  output  1  pulse; clears the RMS accumulators.
- adcAccEnable  output  1  accumulate the current valid sample.
- adcAccLatch  output  1  pulse; latch the accumulator results.
- adcArmed  output  1  in ARMED.
- adcBusy  output  1  state not IDLE.
- adcWindowLength  output  COUNT_WIDTH  valid samples accumulated in the last window.
- adcEventCount  output  EVENT_WIDTH  completed windows since reset.

Behaviour:
- States: IDLE, ARMED, ACQUIRE, LATCH, HOLDOFF. All outputs are registered.
- Reset: state IDLE; all outputs 0; all counters 0.
- IDLE:
  - adcArm -> ARMED.
  - adcAccClear pulses 1 cycle on the transition.
- ARMED:
  - adcArmed = 1.
  - On adcValid & adcExceedsThreshold -> ACQUIRE. That sample counts as the first accumulated sample.
  - On the following cycle, adcAccEnable = 1 and the length counter = 1.
- ACQUIRE:
  - adcAccEnable = adcValid & adcUseThisSample, registered one cycle so it aligns with the data delayed by one register downstream.
  - Length counter increments per enabled sample and saturates at all-ones.
  - Exit to LATCH on the first adcValid with adcUseThisSample = 0, or when the length reaches a nonzero adcMaxWindow.
- LATCH:
  - One cycle.
  - adcAccLatch = 1.
  - adcWindowLength <= length counter.
  - adcEventCount increments and wraps modulo 2^EVENT_WIDTH.
  - Then -> HOLDOFF.
- HOLDOFF:
  - Counts adcValid samples up to adcHoldoff; adcHoldoff = 0 means zero extra cycles.
  - On expiry: if adcAutoRearm, -> ARMED with adcAccClear pulsed; else -> IDLE.
- Abort:
  - adcAbort in any state -> IDLE next cycle.
  - adcAccEnable drops the same cycle it is sampled.
  - No adcAccLatch and no event increment.
  - Abort has priority over adcArm and over threshold.
- Ignored inputs:
  - adcArm outside IDLE is ignored.
  - adcExceedsThreshold outside ARMED is ignored (a re-trigger inside ACQUIRE only extends the window via adcUseThisSample).
- Latency:
  - Threshold sample to first adcAccEnable: 1 cycle.
  - Window end to adcAccLatch: 2 cycles.
- adcValid low: the FSM holds and no counters advance, except the abort path.

Optional Feature:
- Macro: ADC_WINDOW_TIMEOUT_EN.
- Enabled:
  - Adds input adcTimeout [COUNT_WIDTH] and output adcForced [1].
  - In ARMED, count valid samples. If the count reaches a nonzero adcTimeout with no threshold, force entry to ACQUIRE.
  - The forced window is exactly adcMaxWindow samples (adcUseThisSample is ignored); if adcMaxWindow = 0, it is 1 sample.
  - adcForced is set with adcAccLatch and cleared on the next arm.
- Disabled: ports absent; ARMED waits indefinitely.

Decomposition:
- Shared package adc_window_pkg:
  - state enum.
  - COUNT_WIDTH and EVENT_WIDTH defaults.
  - Encoding constants used by the CSR readout.
- Sub-module sat_counter (saturating/loadable valid-gated counter), instantiated for the window length, holdoff and timeout counters.

Test Plan:
- Arm; threshold at sample 10; adcUseThisSample high for samples 10-29 -> adcAccEnable high for exactly 20 valid samples; adcAccLatch 2 cycles after sample 30; adcWindowLength = 20; adcEventCount = 1.
- Same stimulus with adcMaxWindow = 8 -> latch after 8 samples; adcWindowLength = 8.
- adcAutoRearm = 1, adcHoldoff = 5, two threshold bursts 3 samples apart after latch -> second burst ignored; a burst 6 samples after latch is captured; adcEventCount = 2.
- adcAbort mid-ACQUIRE (sample 15 of 20) -> IDLE next cycle; no adcAccLatch; adcEventCount unchanged; adcWindowLength retains its previous value.
- adcValid toggling 1-of-3 during the window -> length counts valid samples only; adcAsync reset mid-HOLDOFF -> all outputs 0 immediately.
- With ADC_WINDOW_TIMEOUT_EN: adcTimeout = 100, adcMaxWindow = 4, no threshold -> forced window of 4 samples; adcForced = 1 at latch.
